// File: rtl/n64_resp_rx_pkg.sv
// Shared definitions for the N64 controller reply receiver.
//  - Protocol constants (bit period, poll command, poll reply length).
//  - FSM state encodings as 3-bit constants, so later bus-turnaround logic can
//    decode the same values without depending on the receiver module.
//  - Small helper used to size counters from two timeout limits.
package n64_resp_rx_pkg;

    // Protocol constants
    localparam int unsigned N64_BIT_US    = 4;
    localparam logic [7:0]  N64_POLL_CMD  = 8'h01;
    localparam int unsigned N64_POLL_BITS = 32;

    // Receiver FSM encodings (3 bits)
    localparam logic [2:0] N64_ST_IDLE       = 3'd0;
    localparam logic [2:0] N64_ST_WAIT_START = 3'd1;
    localparam logic [2:0] N64_ST_MEAS_LOW   = 3'd2;
    localparam logic [2:0] N64_ST_MEAS_HIGH  = 3'd3;
    localparam logic [2:0] N64_ST_DONE       = 3'd4;

    typedef enum logic [2:0] {
        StIdle      = N64_ST_IDLE,
        StWaitStart = N64_ST_WAIT_START,
        StMeasLow   = N64_ST_MEAS_LOW,
        StMeasHigh  = N64_ST_MEAS_HIGH,
        StDone      = N64_ST_DONE
    } rx_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/n64_line_sync.sv
// Two-flop synchronizer plus edge detector for the open-drain N64 data line.
// All flops reset to 1 (idle-high line) so leaving reset never shows a false edge.
// Ports:
//  clk      in  system clock
//  reset    in  asynchronous active-high reset
//  din_i    in  raw line, asynchronous to clk
//  level_o  out synchronized line level
//  fall_o   out 1-cycle pulse on the first synchronized low after high
//  rise_o   out 1-cycle pulse on the first synchronized high after low
module n64_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic din_i,
    output logic level_o,
    output logic fall_o,
    output logic rise_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = din_i;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level_o = sync_q;
    assign fall_o  = prev_q & ~sync_q;
    assign rise_o  = ~prev_q & sync_q;

endmodule

// File: rtl/n64_resp_rx.sv
// N64 controller reply receiver.
// Armed by a pulse when the command generator releases the line, it waits for the
// controller's first falling edge, then classifies each bit by its low-pulse width
// (short low = 1, long low = 0), shifts in BITS data bits MSB first, and expects a
// short-low stop pulse. A good frame updates data with a 1-cycle valid strobe; a
// timeout or bad stop pulse produces a 1-cycle err strobe and leaves data alone.
// Ports:
//  clk    in   system clock
//  reset  in   asynchronous active-high reset
//  arm    in   1-cycle pulse, start listening (ignored while busy)
//  din    in   raw data line (idle high)
//  data   out  last good reply, data[BITS-1] is the first bit received
//  valid  out  1-cycle pulse, data updated
//  err    out  1-cycle pulse, frame aborted
//  busy   out  high from accepted arm until valid/err
module n64_resp_rx
    import n64_resp_rx_pkg::*;
#(
    parameter int unsigned CLK_PER_US  = 12,
    parameter int unsigned BITS        = 32,
    parameter int unsigned START_TO_US = 64,
    parameter int unsigned LEVEL_TO_US = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            arm,
    input  logic            din,
    output logic [BITS-1:0] data,
    output logic            valid,
    output logic            err,
    output logic            busy
);

    localparam int unsigned THRESH   = 2 * CLK_PER_US;
    localparam int unsigned START_TO = START_TO_US * CLK_PER_US;
    localparam int unsigned LEVEL_TO = LEVEL_TO_US * CLK_PER_US;
    localparam int unsigned CNT_MAX  = max_u(START_TO, LEVEL_TO);
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
    localparam int unsigned NB_W     = $clog2(BITS + 1);

    localparam logic [CNT_W-1:0] START_TO_C = CNT_W'(START_TO);
    localparam logic [CNT_W-1:0] LEVEL_TO_C = CNT_W'(LEVEL_TO);
    localparam logic [CNT_W-1:0] CNT_MAX_C  = CNT_W'(CNT_MAX);
    localparam logic [NB_W-1:0]  BITS_C     = NB_W'(BITS);

    logic line_level, line_fall, line_rise;

    n64_line_sync u_line_sync (
        .clk     (clk),
        .reset   (reset),
        .din_i   (din),
        .level_o (line_level),
        .fall_o  (line_fall),
        .rise_o  (line_rise)
    );

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NB_W-1:0]  nbits_q, nbits_d;
    logic [BITS-1:0]  shift_q, shift_d;
    logic [BITS-1:0]  data_q, data_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;

    logic [CNT_W-1:0] cnt_inc;
    logic             bit_val;

    // Saturating increment so a stuck line can never wrap back below a limit.
    assign cnt_inc = (cnt_q == CNT_MAX_C) ? cnt_q : cnt_q + 1'b1;
    // Short low pulse decodes as 1.
    assign bit_val = (32'(cnt_q) < THRESH);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nbits_d = nbits_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        busy_d  = busy_q;

        unique case (state_q)
            StIdle: begin
                busy_d = 1'b0;
                if (arm) begin
                    state_d = StWaitStart;
                    cnt_d   = '0;
                    nbits_d = '0;
                    busy_d  = 1'b1;
                end
            end

            // Edges win over a coincident timeout in every waiting state.
            StWaitStart: begin
                if (line_fall) begin
                    state_d = StMeasLow;
                    cnt_d   = '0;
                end else if (cnt_q == START_TO_C) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            StMeasLow: begin
                if (line_rise) begin
                    if (nbits_q < BITS_C) begin
                        shift_d = (shift_q << 1) | BITS'(bit_val);
                        nbits_d = nbits_q + 1'b1;
                        cnt_d   = '0;
                        state_d = StMeasHigh;
                    end else if (bit_val) begin
                        state_d = StDone;
                    end else begin
                        // Stop pulse must be a short low.
                        state_d = StIdle;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                    end
                end else if (cnt_q == LEVEL_TO_C) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                end else if (!line_level) begin
                    cnt_d = cnt_inc;
                end
            end

            StMeasHigh: begin
                if (line_fall) begin
                    state_d = StMeasLow;
                    cnt_d   = '0;
                end else if (cnt_q == LEVEL_TO_C) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            StDone: begin
                data_d  = shift_q;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            nbits_q <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nbits_q <= nbits_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign data  = data_q;
    assign valid = valid_q;
    assign err   = err_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_n64_resp_rx.sv
// Self-checking bench for n64_resp_rx with a controller-side line model.
module tb_n64_resp_rx;

    localparam int unsigned CPU = 4;
    localparam int unsigned NB  = 32;
    localparam int unsigned BIT_CYC = 4 * CPU;

    logic          clk = 1'b0;
    logic          reset;
    logic          arm;
    logic          din;
    logic [NB-1:0] data;
    logic          valid;
    logic          err;
    logic          busy;

    always #5 clk = ~clk;

    n64_resp_rx #(
        .CLK_PER_US  (CPU),
        .BITS        (NB),
        .START_TO_US (64),
        .LEVEL_TO_US (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .arm   (arm),
        .din   (din),
        .data  (data),
        .valid (valid),
        .err   (err),
        .busy  (busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: what data must show, whether busy must be high, and which
    // single outcome (0 none, 1 valid, 2 err) the current armed frame must end in.
    logic [NB-1:0] model_data = '0;
    logic [NB-1:0] model_pending = '0;
    logic          model_busy = 1'b0;
    int            expect_kind = 0;
    int            n_valid = 0;
    int            n_err = 0;
    int            base_v = 0;
    int            base_e = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            check("valid_err_exclusive", 64'(valid & err), 64'd0);
            if (valid) begin
                check("valid_allowed", 64'(expect_kind), 64'd1);
                check("valid_data", 64'(data), 64'(model_pending));
                check("valid_busy_low", 64'(busy), 64'd0);
                model_data  = model_pending;
                model_busy  = 1'b0;
                expect_kind = 0;
                n_valid++;
            end
            if (err) begin
                check("err_allowed", 64'(expect_kind), 64'd2);
                check("err_busy_low", 64'(busy), 64'd0);
                model_busy  = 1'b0;
                expect_kind = 0;
                n_err++;
            end
            check("data_hold", 64'(data), 64'(model_data));
            check("busy", 64'(busy), 64'(model_busy));
        end
    end

    task automatic hold(input logic v, input int n);
        din = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // '1' = short low (~1 us), '0' = long low (~3 us), with some jitter.
    task automatic send_bit(input logic b);
        int lo;
        lo = b ? int'($urandom_range(3, 5)) : int'($urandom_range(10, 14));
        hold(1'b0, lo);
        hold(1'b1, BIT_CYC - lo);
    endtask

    task automatic send_bits(input logic [NB-1:0] w, input int n);
        for (int i = 0; i < n; i++) send_bit(w[NB-1-i]);
    endtask

    task automatic send_stop(input int lo);
        hold(1'b0, lo);
        hold(1'b1, BIT_CYC);
    endtask

    task automatic mark();
        base_v = n_valid;
        base_e = n_err;
    endtask

    task automatic pulse_arm();
        @(posedge clk);
        #1 arm = 1'b1;
        @(posedge clk);
        #1 arm = 1'b0;
        model_busy = 1'b1;
    endtask

    task automatic wait_outcome(input string name, input int want, input int max_cyc,
                                output int cyc);
        int got;
        cyc = 0;
        while (n_valid == base_v && n_err == base_e && cyc < max_cyc) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        got = (n_valid != base_v) ? 1 : (n_err != base_e) ? 2 : 0;
        check(name, 64'(got), 64'(want));
    endtask

    task automatic good_frame(input logic [NB-1:0] w);
        int cyc;
        model_pending = w;
        expect_kind = 1;
        mark();
        pulse_arm();
        hold(1'b1, int'($urandom_range(4, 20)));
        send_bits(w, NB);
        send_stop(CPU);
        wait_outcome("frame_valid", 1, 20, cyc);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        reset = 1'b1;
        arm   = 1'b0;
        din   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data", 64'(data), 64'd0);
        check("reset_valid", 64'(valid), 64'd0);
        check("reset_err", 64'(err), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        // arm coincident with reset must be ignored
        arm = 1'b1;
        @(posedge clk);
        #1 arm = 1'b0;
        check("arm_in_reset", 64'(busy), 64'd0);
        reset = 1'b0;
        hold(1'b1, 5);

        // Known reply, pinned by a literal.
        good_frame(32'h8000_7F81);
        check("literal_frame", 64'(data), 64'h8000_7F81);

        // Start timeout: line stays high.
        expect_kind = 2;
        mark();
        pulse_arm();
        din = 1'b1;
        wait_outcome("start_timeout", 2, 400, cyc);
        check("start_timeout_window", 64'(cyc >= 256 && cyc <= 262), 64'd1);
        check("start_timeout_data", 64'(data), 64'h8000_7F81);

        // 16 good bits, then the line sticks low.
        expect_kind = 2;
        mark();
        pulse_arm();
        hold(1'b1, 8);
        send_bits(32'h1234_5678, 16);
        hold(1'b0, 60);
        hold(1'b1, 8);
        wait_outcome("level_timeout", 2, 20, cyc);
        good_frame(32'hCAFE_0042);

        // Bad stop pulse (3 us low).
        expect_kind = 2;
        mark();
        pulse_arm();
        hold(1'b1, 8);
        send_bits(32'hDEAD_BEEF, NB);
        send_stop(3 * CPU);
        wait_outcome("bad_stop", 2, 20, cyc);
        check("bad_stop_data", 64'(data), 64'hCAFE_0042);

        // Reset mid-frame after 10 bits.
        expect_kind = 0;
        mark();
        pulse_arm();
        hold(1'b1, 8);
        send_bits(32'hA5A5_A5A5, 10);
        din = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b1;
        model_data = '0;
        model_busy = 1'b0;
        #1;
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_data", 64'(data), 64'd0);
        check("midreset_valid", 64'(valid | err), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        hold(1'b1, 10);
        check("midreset_no_event", 64'(n_valid - base_v + n_err - base_e), 64'd0);
        good_frame(32'h0F0F_F0F0);

        // Line glitches while idle: no effect.
        expect_kind = 0;
        mark();
        for (int i = 0; i < 8; i++) begin
            hold(1'b0, int'($urandom_range(1, 14)));
            hold(1'b1, int'($urandom_range(1, 10)));
        end
        hold(1'b1, 30);
        check("idle_glitch_no_event", 64'(n_valid - base_v + n_err - base_e), 64'd0);

        // arm re-pulsed during a frame must not restart it.
        model_pending = 32'h5A3C_C3A5;
        expect_kind = 1;
        mark();
        pulse_arm();
        fork
            begin
                hold(1'b1, 8);
                send_bits(32'h5A3C_C3A5, NB);
                send_stop(CPU);
            end
            begin
                repeat (100) @(posedge clk);
                #1 arm = 1'b1;
                @(posedge clk);
                #1 arm = 1'b0;
            end
        join
        wait_outcome("rearm_frame", 1, 20, cyc);

        // Random replies.
        for (int k = 0; k < 6; k++) begin
            good_frame(NB'($urandom));
            hold(1'b1, int'($urandom_range(2, 12)));
        end

        hold(1'b1, 10);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
